// File: rtl/act_pkg.sv
// Shared constants and state encoding for the activation SRAM path.
// The write-side and CIM driver blocks use the same constants.
package act_pkg;

    localparam int ACT_ROWS   = 32;
    localparam int ACT_ROW_W  = 768;
    localparam int ACT_BEAT_W = 32;
    localparam int ACT_BEATS  = ACT_ROW_W / ACT_BEAT_W;

    // state      | meaning
    // ACT_IDLE   | waiting for start
    // ACT_RD     | SRAM read cycle (ceb low for one cycle)
    // ACT_CAP    | SRAM Q valid, captured into the row buffer
    // ACT_STREAM | presenting beats of the buffered row
    // ACT_FIN    | one-cycle done pulse
    typedef enum logic [2:0] {
        ACT_IDLE   = 3'd0,
        ACT_RD     = 3'd1,
        ACT_CAP    = 3'd2,
        ACT_STREAM = 3'd3,
        ACT_FIN    = 3'd4
    } act_rs_state_t;

endpackage

// File: rtl/act_row_streamer.sv
// Activation row streamer: reads a run of consecutive rows from the
// activation SRAM and streams each row as 32-bit beats over valid/ready.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start, row_base, row_cnt run command (sampled only when idle)
//   busy, done               run status; done is a one-cycle pulse
//   sram_ceb/web/a_row/q     SRAM read port (read only, web held high)
//   out_valid/ready/data     beat stream
//   out_row, out_beat        source row and beat index of the current beat
//   out_last                 final beat of the final row
module act_row_streamer
    import act_pkg::*;
#(
    parameter int ROW_AW = 5,
    parameter int ROW_W  = 768,
    parameter int BEAT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROW_AW-1:0] row_base,
    input  logic [ROW_AW:0]   row_cnt,
    output logic              busy,
    output logic              done,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ROW_AW-1:0] sram_a_row,
    input  logic [ROW_W-1:0]  sram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic [ROW_AW-1:0] out_row,
    output logic [4:0]        out_beat,
    output logic              out_last
);

    localparam int         BEATS     = ROW_W / BEAT_W;
    localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);

    act_rs_state_t     state_q, state_d;
    logic [ROW_AW-1:0] row_ptr_q, row_ptr_d;
    logic [ROW_AW:0]   rows_left_q, rows_left_d;
    logic [4:0]        beat_q, beat_d;
    logic [ROW_W-1:0]  row_buf_q, row_buf_d;
    logic              xfer;

    assign xfer = (state_q == ACT_STREAM) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACT_IDLE;
            row_ptr_q   <= '0;
            rows_left_q <= '0;
            beat_q      <= '0;
            row_buf_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_ptr_q   <= row_ptr_d;
            rows_left_q <= rows_left_d;
            beat_q      <= beat_d;
            row_buf_q   <= row_buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_ptr_d   = row_ptr_q;
        rows_left_d = rows_left_q;
        beat_d      = beat_q;
        row_buf_d   = row_buf_q;
        case (state_q)
            ACT_IDLE: begin
                if (start) begin
                    row_ptr_d   = row_base;
                    rows_left_d = row_cnt;
                    state_d     = (row_cnt == '0) ? ACT_FIN : ACT_RD;
                end
            end
            ACT_RD: state_d = ACT_CAP;
            ACT_CAP: begin
                // SRAM Q is only valid in this cycle
                row_buf_d = sram_q;
                beat_d    = '0;
                state_d   = ACT_STREAM;
            end
            ACT_STREAM: begin
                if (xfer) begin
                    if (beat_q == LAST_BEAT) begin
                        rows_left_d = rows_left_q - 1'b1;
                        // row pointer wraps naturally at the address width
                        row_ptr_d   = row_ptr_q + 1'b1;
                        state_d     = (rows_left_q == (ROW_AW+1)'(1)) ? ACT_FIN : ACT_RD;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ACT_FIN: state_d = ACT_IDLE;
            default: state_d = ACT_IDLE;
        endcase
    end

    assign sram_web   = 1'b1;
    assign sram_a_row = row_ptr_q;
    assign out_row    = row_ptr_q;
    assign out_beat   = beat_q;

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        sram_ceb  = 1'b1;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state_q)
            ACT_RD: begin
                busy     = 1'b1;
                sram_ceb = 1'b0;
            end
            ACT_CAP: busy = 1'b1;
            ACT_STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = row_buf_q[beat_q*BEAT_W +: BEAT_W];
                out_last  = (beat_q == LAST_BEAT) && (rows_left_q == (ROW_AW+1)'(1));
            end
            ACT_FIN: done = 1'b1;
            default: ;
        endcase
    end

endmodule
